// File: rtl/lsu_dbus_master_pkg.sv
// Shared configuration for the load/store unit: datapath widths, FSM state
// codes, func3 access encodings and small helpers for lane/alignment math.
package lsu_dbus_master_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;

  // LSU transaction FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // func3: bits [1:0] give the access size, bit 2 selects zero-extension
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dbus_master_ldext.sv
// Load data extraction: shifts the addressed bytes of a 64-bit bus word down
// to bit 0 and sign- or zero-extends them according to func3.
//   i_rdata  : raw 64-bit read data from the bus
//   i_off    : byte offset of the access inside the doubleword
//   i_func3  : access size/sign
//   o_data   : aligned, extended load result
module lsu_ldext
  import lsu_dbus_master_pkg::*;
(
  input  logic [63:0]          i_rdata,
  input  logic [2:0]           i_off,
  input  logic [2:0]           i_func3,
  output logic [CPU_WIDTH-1:0] o_data
);

  logic [63:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_sh;
    case (i_func3)
      F3_B:  o_data = {{(CPU_WIDTH-8){w_sh[7]}},   w_sh[7:0]};
      F3_H:  o_data = {{(CPU_WIDTH-16){w_sh[15]}}, w_sh[15:0]};
      F3_W:  o_data = {{(CPU_WIDTH-32){w_sh[31]}}, w_sh[31:0]};
      F3_BU: o_data = {{(CPU_WIDTH-8){1'b0}},      w_sh[7:0]};
      F3_HU: o_data = {{(CPU_WIDTH-16){1'b0}},     w_sh[15:0]};
      F3_WU: o_data = {{(CPU_WIDTH-32){1'b0}},     w_sh[31:0]};
      default: o_data = w_sh;  // LD and 111
    endcase
  end

endmodule

// File: rtl/lsu_dbus_master.sv
// Load/store unit behind the EX->LS register. Memory ops run a req/gnt/rvalid
// transaction on the 64-bit data bus while stalling upstream; non-memory ops
// and misaligned accesses complete combinationally in the same cycle.
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_lsu_*              : execute result/address, store data, rd, func3, ld/st enables
//   s_lsu_diffpc         : difftest PC, forwarded to s_wbu_diffpc
//   o_lsu_stall          : freeze upstream registers
//   o_lsu_misalign       : one-cycle misaligned-access flag
//   o_wbu_*              : write-back result, rd id, rd write enable, valid
//   o_dbus_* / i_dbus_*  : data bus request, write lanes and read response
module lsu_dbus_master
  import lsu_dbus_master_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CPU_WIDTH-1:0] i_lsu_exres,
  input  logic [CPU_WIDTH-1:0] i_lsu_rs2,
  input  logic [REG_ADDRW-1:0] i_lsu_rdid,
  input  logic                 i_lsu_rdwen,
  input  logic [2:0]           i_lsu_func3,
  input  logic                 i_lsu_lden,
  input  logic                 i_lsu_sten,
  input  logic [CPU_WIDTH-1:0] s_lsu_diffpc,
  output logic                 o_lsu_stall,
  output logic                 o_lsu_misalign,
  output logic [CPU_WIDTH-1:0] o_wbu_res,
  output logic [REG_ADDRW-1:0] o_wbu_rdid,
  output logic                 o_wbu_rdwen,
  output logic                 o_wbu_valid,
  output logic [CPU_WIDTH-1:0] s_wbu_diffpc,
  output logic                 o_dbus_req,
  input  logic                 i_dbus_gnt,
  output logic                 o_dbus_wen,
  output logic [CPU_WIDTH-1:0] o_dbus_addr,
  output logic [63:0]          o_dbus_wdata,
  output logic [7:0]           o_dbus_wmask,
  input  logic                 i_dbus_rvalid,
  input  logic [63:0]          i_dbus_rdata
);

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [CPU_WIDTH-1:0] r_ldata;
  logic [CPU_WIDTH-1:0] w_ldext;
  logic [2:0]           w_off;
  logic                 w_memop;
  logic                 w_mis;
  logic                 w_issue;
  logic                 w_stall;
  logic                 w_capture;

  assign w_off   = i_lsu_exres[2:0];
  assign w_memop = i_lsu_lden | i_lsu_sten;
  assign w_mis   = w_memop & misaligned(i_lsu_func3, w_off);
  // REQ is only reachable with an aligned op, and the frozen upstream keeps it stable.
  assign w_issue = ((r_state == ST_IDLE) & w_memop & ~w_mis) | (r_state == ST_REQ);
  assign w_stall = w_issue | (r_state == ST_WAIT);
  assign w_capture = (r_state == ST_WAIT) & i_dbus_rvalid;

  lsu_ldext u_ldext (
    .i_rdata (i_dbus_rdata),
    .i_off   (w_off),
    .i_func3 (i_lsu_func3),
    .o_data  (w_ldext)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_REQ: begin
        if (w_issue) begin
          if (i_dbus_gnt) w_next = i_lsu_sten ? ST_DONE : ST_WAIT;
          else            w_next = ST_REQ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: if (i_dbus_rvalid) w_next = ST_DONE;
      default: w_next = ST_IDLE;  // DONE never re-issues the held op
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ldata <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_ldata <= w_ldext;
    end
  end

  // Everything is forced low while reset is held, including the pass-through paths.
  always_comb begin
    o_lsu_stall    = 1'b0;
    o_lsu_misalign = 1'b0;
    o_wbu_res      = '0;
    o_wbu_rdid     = '0;
    o_wbu_rdwen    = 1'b0;
    o_wbu_valid    = 1'b0;
    s_wbu_diffpc   = '0;
    o_dbus_req     = 1'b0;
    o_dbus_wen     = 1'b0;
    o_dbus_addr    = '0;
    o_dbus_wdata   = '0;
    o_dbus_wmask   = '0;
    if (i_rst_n) begin
      o_lsu_stall    = w_stall;
      o_lsu_misalign = (r_state == ST_IDLE) & w_mis;
      o_wbu_valid    = ~w_stall;
      o_wbu_rdid     = i_lsu_rdid;
      s_wbu_diffpc   = s_lsu_diffpc;
      o_dbus_req     = w_issue;
      o_wbu_res      = ((r_state == ST_DONE) & i_lsu_lden) ? r_ldata : i_lsu_exres;
      if (!w_stall) begin
        if (r_state == ST_DONE) o_wbu_rdwen = i_lsu_rdwen & i_lsu_lden;
        else                    o_wbu_rdwen = i_lsu_rdwen & ~w_memop;
      end
      if (w_issue) begin
        o_dbus_addr = {i_lsu_exres[CPU_WIDTH-1:3], 3'b000};
        if (i_lsu_sten) begin
          o_dbus_wen   = 1'b1;
          o_dbus_wmask = size_mask(i_lsu_func3) << w_off;
          o_dbus_wdata = i_lsu_rs2 << {w_off, 3'b000};
        end
      end
    end
  end

endmodule
